// File: rtl/char_tile_mover.sv
// char_tile_mover: tile-based character movement with map lookup handshake and per-tick pixel animation
// Ports: clk, rst (async, active-low), move_tick (frame strobe), dir_valid/dir (0=L 1=R 2=U 3=D),
//   map_req/map_x/map_y -> map, map_ack/map_walkable <- map, tile_x/tile_y (committed tile),
//   charactor_posi {pix_x,pix_y}, moving (in MOVE), blocked (1-cycle reject pulse).
// Optional CHAR_TURN_BUFFER_EN: one-entry buffer for requests arriving outside IDLE.
module char_tile_mover #(
  parameter int MAP_W   = 20,
  parameter int MAP_H   = 15,
  parameter int TILE_PX = 32,
  parameter int STEP_PX = 4,
  parameter int PIX_W   = 10,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  localparam int XW = $clog2(MAP_W),
  localparam int YW = $clog2(MAP_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             move_tick,
  input  logic             dir_valid,
  input  logic [1:0]       dir,
  output logic             map_req,
  output logic [XW-1:0]    map_x,
  output logic [YW-1:0]    map_y,
  input  logic             map_ack,
  input  logic             map_walkable,
  output logic [XW-1:0]    tile_x,
  output logic [YW-1:0]    tile_y,
  output logic [2*PIX_W-1:0] charactor_posi,
  output logic             moving,
  output logic             blocked
);
  localparam int N  = TILE_PX / STEP_PX;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, WAIT_MAP, MOVE} state_t;
  state_t state, state_d;
  logic [PIX_W-1:0] pix_x, pix_y, step_x, step_y, end_x, end_y;
  logic [CW-1:0] cnt;
  logic [1:0] dir_q, rdir;
  logic req, oob, last;
  logic [XW-1:0] tx_t;
  logic [YW-1:0] ty_t;
`ifdef CHAR_TURN_BUFFER_EN
  logic buf_v;
  logic [1:0] buf_dir;
  // a live request in the IDLE cycle takes priority over the buffered one
  assign req  = dir_valid | buf_v;
  assign rdir = dir_valid ? dir : buf_dir;
`else
  assign req  = dir_valid;
  assign rdir = dir;
`endif
  assign charactor_posi = {pix_x, pix_y};
  always_comb begin
    oob = rdir == 2'd0 ? tile_x == '0 :
          rdir == 2'd1 ? tile_x == XW'(MAP_W - 1) :
          rdir == 2'd2 ? tile_y == '0 : tile_y == YW'(MAP_H - 1);
    tx_t = rdir == 2'd0 ? tile_x - XW'(1) : rdir == 2'd1 ? tile_x + XW'(1) : tile_x;
    ty_t = rdir == 2'd2 ? tile_y - YW'(1) : rdir == 2'd3 ? tile_y + YW'(1) : tile_y;
    last = cnt == CW'(N - 1);
    step_x = dir_q[0] ? pix_x + PIX_W'(STEP_PX) : pix_x - PIX_W'(STEP_PX);
    step_y = dir_q[0] ? pix_y + PIX_W'(STEP_PX) : pix_y - PIX_W'(STEP_PX);
    // map_x/map_y keep the target tile through MOVE; landing snaps to its exact pixel origin
    end_x = PIX_W'(map_x) * PIX_W'(TILE_PX);
    end_y = PIX_W'(map_y) * PIX_W'(TILE_PX);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state == IDLE     ? (req && !oob ? WAIT_MAP : IDLE) :
              state == WAIT_MAP ? (map_ack ? (map_walkable ? MOVE : IDLE) : WAIT_MAP) :
              state == MOVE     ? (move_tick && last ? IDLE : MOVE) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tile_x  <= XW'(START_X);
      tile_y  <= YW'(START_Y);
      pix_x   <= PIX_W'(START_X * TILE_PX);
      pix_y   <= PIX_W'(START_Y * TILE_PX);
      map_req <= 1'b0;
      map_x   <= '0;
      map_y   <= '0;
      moving  <= 1'b0;
      blocked <= 1'b0;
      dir_q   <= 2'd0;
      cnt     <= '0;
`ifdef CHAR_TURN_BUFFER_EN
      buf_v   <= 1'b0;
      buf_dir <= 2'd0;
`endif
    end else begin
      blocked <= 1'b0;
`ifdef CHAR_TURN_BUFFER_EN
      if (state != IDLE && dir_valid) begin
        buf_v   <= 1'b1;
        buf_dir <= dir;
      end
`endif
      case (state)
        IDLE: begin
`ifdef CHAR_TURN_BUFFER_EN
          buf_v <= 1'b0;
`endif
          if (req) begin
            dir_q <= rdir;
            if (oob) blocked <= 1'b1;
            else begin
              map_req <= 1'b1;
              map_x   <= tx_t;
              map_y   <= ty_t;
            end
          end
        end
        WAIT_MAP: if (map_ack) begin
          map_req <= 1'b0;
          cnt     <= '0;
          moving  <= map_walkable;
          blocked <= !map_walkable;
`ifdef CHAR_TURN_BUFFER_EN
          if (!map_walkable) buf_v <= 1'b0;
`endif
        end
        MOVE: if (move_tick) begin
          cnt   <= cnt + CW'(1);
          pix_x <= last ? end_x : dir_q[1] ? pix_x : step_x;
          pix_y <= last ? end_y : dir_q[1] ? step_y : pix_y;
          if (last) begin
            tile_x <= map_x;
            tile_y <= map_y;
            moving <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_char_tile_mover.sv
// tb_char_tile_mover: directed scoreboard bench for char_tile_mover
module tb_char_tile_mover;
  localparam int MAP_W = 20, MAP_H = 15, TILE = 32, STEP = 4, N = TILE / STEP;
  logic clk = 0, rst = 1, move_tick = 0, dir_valid = 0, map_ack = 0, map_walkable = 0;
  logic [1:0] dir = 0;
  logic map_req, moving, blocked;
  logic [4:0] map_x, tile_x;
  logic [3:0] map_y, tile_y;
  logic [19:0] charactor_posi;
  int pass_n = 0, tot_n = 0, fail_n = 0;
  int mtx, mty, ttx, tty, mpx, mpy, mdir, mcnt;
  logic [19:0] pos_q[$];
  int lk_q[$];
  char_tile_mover dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .dir_valid(dir_valid), .dir(dir),
    .map_req(map_req), .map_x(map_x), .map_y(map_y), .map_ack(map_ack),
    .map_walkable(map_walkable), .tile_x(tile_x), .tile_y(tile_y),
    .charactor_posi(charactor_posi), .moving(moving), .blocked(blocked)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tot_n++;
    assert (got === want) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  task automatic model_reset;
    mtx = 1; mty = 1; mpx = 32; mpy = 32; mcnt = 0;
    pos_q.delete();
    lk_q.delete();
  endtask
  task automatic wait_lookup;
    int k;
    k = 0;
    while (map_req !== 1'b1 && k < 8) begin
      cyc;
      k++;
    end
    if (map_req !== 1'b1) begin
      chk("lookup_timeout", map_req, 1);
      lk_q.delete();
    end else begin
      int e;
      e = lk_q.pop_front();
      chk("map_x", map_x, e / 64);
      chk("map_y", map_y, e % 64);
    end
  endtask
  task automatic request(input int d);
    int nx, ny;
    bit oob;
    nx = d == 0 ? mtx - 1 : d == 1 ? mtx + 1 : mtx;
    ny = d == 2 ? mty - 1 : d == 3 ? mty + 1 : mty;
    oob = nx < 0 || nx >= MAP_W || ny < 0 || ny >= MAP_H;
    dir_valid = 1; dir = 2'(d);
    cyc;
    dir_valid = 0;
    if (oob) begin
      chk("edge_blk", blocked, 1);
      chk("edge_noreq", map_req, 0);
      cyc;
      chk("edge_blk_end", blocked, 0);
      chk("edge_noreq2", map_req, 0);
      chk("edge_tile_x", tile_x, mtx);
      chk("edge_tile_y", tile_y, mty);
    end else begin
      mdir = d; ttx = nx; tty = ny;
      lk_q.push_back(nx * 64 + ny);
      wait_lookup;
    end
  endtask
  task automatic answer(input bit walk, input int delay);
    for (int i = 0; i < delay; i++) begin
      chk("req_held", map_req, 1);
      chk("hold_x", map_x, ttx);
      chk("hold_y", map_y, tty);
      cyc;
    end
    map_ack = 1; map_walkable = walk;
    cyc;
    map_ack = 0; map_walkable = 0;
    chk("req_drop", map_req, 0);
    if (walk) begin
      chk("moving_on", moving, 1);
      chk("no_blk_entry", blocked, 0);
      mcnt = 0;
    end else begin
      chk("wall_blk", blocked, 1);
      chk("wall_still", moving, 0);
      cyc;
      chk("wall_blk_end", blocked, 0);
    end
  endtask
  task automatic ticks(input int n, input bit mv);
    for (int i = 0; i < n; i++) begin
      if (mv) begin
        mpx += mdir == 0 ? -STEP : mdir == 1 ? STEP : 0;
        mpy += mdir == 2 ? -STEP : mdir == 3 ? STEP : 0;
        mcnt++;
      end
      pos_q.push_back({10'(mpx), 10'(mpy)});
      move_tick = 1;
      cyc;
      move_tick = 0;
      chk("posi", charactor_posi, pos_q.pop_front());
      if (mv) begin
        chk("no_blk_moving", blocked, 0);
        if (mcnt == N) begin
          mtx = ttx; mty = tty; mv = 0;
          chk("tile_x", tile_x, mtx);
          chk("tile_y", tile_y, mty);
          chk("move_done", moving, 0);
        end else chk("still_moving", moving, 1);
      end
    end
  endtask
  task automatic full_move(input int d);
    request(d);
    answer(1, 0);
    ticks(N, 1);
  endtask
  initial begin
    model_reset;
    #2 rst = 0;
    #1;
    chk("rst_tile_x", tile_x, 1);
    chk("rst_tile_y", tile_y, 1);
    chk("rst_posi", charactor_posi, {10'd32, 10'd32});
    chk("rst_req", map_req, 0);
    chk("rst_map_x", map_x, 0);
    chk("rst_moving", moving, 0);
    chk("rst_blocked", blocked, 0);
    cyc;
    rst = 1;
    cyc;
    full_move(1);
    request(2);
    answer(0, 5);
    ticks(3, 0);
    chk("wall_tile_y", tile_y, 1);
    full_move(0);
    full_move(0);
    request(0);
    for (int i = 0; i < 13; i++) full_move(3);
    request(3);
    request(1);
    answer(1, 0);
    ticks(3, 1);
    #2 rst = 0;
    #1;
    model_reset;
    chk("mid_rst_tile_x", tile_x, 1);
    chk("mid_rst_tile_y", tile_y, 1);
    chk("mid_rst_posi", charactor_posi, {10'd32, 10'd32});
    chk("mid_rst_moving", moving, 0);
    chk("mid_rst_req", map_req, 0);
    cyc;
    rst = 1;
    cyc;
    full_move(3);
    request(1);
    answer(1, 0);
    dir_valid = 1; dir = 2'd1;
    cyc;
    dir = 2'd3;
    cyc;
    dir_valid = 0;
    ticks(N, 1);
`ifdef CHAR_TURN_BUFFER_EN
    cyc;
    chk("buf_req_first_idle", map_req, 1);
    mdir = 3; ttx = mtx; tty = mty + 1;
    lk_q.push_back(ttx * 64 + tty);
    wait_lookup;
    answer(1, 0);
    ticks(N, 1);
`else
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("no_buf_req", map_req, 0);
    end
`endif
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/char_tile_mover.md
Name: char_tile_mover

Overview:
- Parametrised, tile-based character movement controller; successor to the fixed 4-direction path-check character block.
- Accepts a direction request and checks the target tile against an external map via a req/ack handshake.
- On a walkable target, animates the pixel position across the tile on frame ticks, then commits the new tile.
- Drives the 20-bit packed position consumed by the renderer.

Parameters:
- MAP_W, 20, map width in tiles (>=2)
- MAP_H, 15, map height in tiles (>=2)
- TILE_PX, 32, tile edge in pixels
- STEP_PX, 4, pixels moved per move_tick; TILE_PX must be an integer multiple of STEP_PX
- PIX_W, 10, pixel coordinate width per axis
- START_X, 1, reset tile column (< MAP_W)
- START_Y, 1, reset tile row (< MAP_H)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- move_tick  in  1  one-cycle frame strobe
- dir_valid  in  1  direction request strobe
- dir  in  2  0=left, 1=right, 2=up, 3=down
- map_req  out  1  map lookup request
- map_x  out  $clog2(MAP_W)  lookup column
- map_y  out  $clog2(MAP_H)  lookup row
- map_ack  in  1  lookup complete
- map_walkable  in  1  lookup result, valid with map_ack
- tile_x  out  $clog2(MAP_W)  committed tile column
- tile_y  out  $clog2(MAP_H)  committed tile row
- charactor_posi  out  2*PIX_W  {pix_x, pix_y}, top-left pixel of character
- moving  out  1  high in MOVE
- blocked  out  1  one-cycle pulse on rejected move

Behaviour:
- Reset (rst low, asynchronous):
  - tile = (START_X, START_Y); pix = tile*TILE_PX.
  - state IDLE; map_req=0, map_x=map_y=0, moving=0, blocked=0.
  - Applies mid-operation: any move or lookup is abandoned.
- States: IDLE, WAIT_MAP, MOVE. All outputs registered.
- IDLE, dir_valid=1:
  - Latch dir; compute the target tile.
  - Out of bounds (x=0 & left, x=MAP_W-1 & right, y=0 & up, y=MAP_H-1 & down): blocked=1 next cycle, stay IDLE, no map_req.
  - Otherwise: next cycle map_req=1 with map_x/map_y=target; go to WAIT_MAP.
- WAIT_MAP:
  - map_req, map_x, map_y held stable until map_ack is sampled high. Zero-wait ack is legal.
  - On ack, map_req=0 next cycle.
  - map_walkable=1: go to MOVE, moving=1.
  - map_walkable=0: blocked pulse, return to IDLE.
  - move_tick ignored.
- MOVE:
  - Each move_tick: pixel coordinate on the move axis changes by ±STEP_PX.
  - After TILE_PX/STEP_PX ticks, pix = target*TILE_PX exactly.
  - In that same cycle edge: tile <= target, moving=0, return to IDLE.
  - A move_tick coincident with entry into MOVE is not counted.
- dir_valid outside IDLE: ignored (see optional feature).
- blocked is never asserted while moving=1.
- Pixel arithmetic is unsigned PIX_W; parameters guarantee no overflow, (MAP_W-1)*TILE_PX < 2^PIX_W.
- A new move can be accepted at the earliest one cycle after return to IDLE.

Optional Feature:
- CHAR_TURN_BUFFER_EN defined:
  - One-entry direction buffer; dir_valid in WAIT_MAP or MOVE stores dir, latest request wins.
  - On entry to IDLE, a buffered request is processed in the first IDLE cycle exactly as a dir_valid, then the buffer clears.
  - A dir_valid in that same IDLE cycle overrides the buffer.
  - Buffer cleared by reset and by a blocked result.
- Undefined: no buffer; behaviour as in Behaviour.

Test Plan:
1. Reset, defaults: assert rst low mid-stream -> tile=(1,1), charactor_posi={10'd32,10'd32}, map_req=0, moving=0, blocked=0 immediately.
2. Open move: from (1,1), dir=1 with walkable ack after 0 cycles -> map_x=2, map_y=1; 8 move_ticks step pix_x 32->36...->64; tile_x=2 and moving=0 after the 8th tick.
3. Wall: dir=2 from (2,1), ack with walkable=0 after 5 cycles -> map_req held with map_y=0 for all 5 cycles; single blocked pulse; position unchanged; subsequent move_ticks have no effect.
4. Map edge: at tile_x=0, dir=0 -> blocked pulse, map_req never asserted. At tile_y=14, dir=3 -> same.
5. Reset mid-move: rst low after 3 of 8 ticks -> immediate return to (1,1)/pix (32,32); after release, a new dir accepted normally.
6. CHAR_TURN_BUFFER_EN: dir=1 then dir=3 during MOVE -> on arrival, down lookup issued in first IDLE cycle (map_y=tile_y+1). Without the macro, no lookup is issued.
